updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
Parametrised up/down counter with a programmable modulus, a wrap or saturate mode, a configurable step size, an input prescaler, a synchronous load, and boundary flags. It is the general-purpose successor to the basic enable/inc/dec counter. It sits wherever the design needs event counting, position tracking or divided ticks, and it keeps the existing enable/inc_en/dec_en control style. All outputs are registered or decoded directly from registers.

Parameters:
COUNT_WIDTH, 4, width of counter; legal 2..32
MAX_COUNT, 15, terminal value; legal 1..2^COUNT_WIDTH-1; counting range is 0..MAX_COUNT
SATURATE, 0, 0 = wrap modulo MAX_COUNT+1; 1 = clamp at 0 / MAX_COUNT
STEP, 1, amount added or subtracted per step; legal 1..MAX_COUNT
PRESCALE, 1, number of qualifying cycles per step; legal 1..65535

Ports:
clk  in  1  system clock, all logic on rising edge
s_reset  in  1  synchronous reset, active-high
enable  in  1  counting enable
inc_en  in  1  count-up request
dec_en  in  1  count-down request
load_en  in  1  synchronous load strobe
load_value  in  COUNT_WIDTH  value to load
counter  out  COUNT_WIDTH  current count
at_max  out  1  counter == MAX_COUNT
at_min  out  1  counter == 0
overflow  out  1  one-cycle pulse on an up step that exceeds MAX_COUNT
underflow  out  1  one-cycle pulse on a down step that goes below 0

Behaviour:
- One clock (clk); reset is synchronous and active-high (s_reset).
- Reset values: counter=0, overflow=0, underflow=0, internal prescale count=0. This gives at_min=1, and at_max=0 (MAX_COUNT≥1).
- Priority per cycle: s_reset > load_en > count step > hold.
- Load: counter <= min(load_value, MAX_COUNT). Load ignores enable. It clears the prescale count. No overflow/underflow pulse on load.
- Qualifying cycle: enable=1 AND (inc_en XOR dec_en). If inc_en=dec_en=1, or enable=0, counter and prescale count hold.
- Prescaler:
  - On a qualifying cycle, if prescale count == PRESCALE-1, a step fires and the prescale count returns to 0.
  - Otherwise the prescale count increments.
  - With PRESCALE=1, every qualifying cycle steps.
  - A direction change does not clear the prescale count.
- Arithmetic: computed in COUNT_WIDTH+1 bits, no intermediate truncation.
  - Up, wrap: if counter > MAX_COUNT-STEP, then counter+STEP-(MAX_COUNT+1) and overflow=1; else counter+STEP.
  - Up, saturate: if counter > MAX_COUNT-STEP, then MAX_COUNT and overflow=1 (this includes a step attempted while already at MAX_COUNT).
  - Down, wrap: if counter < STEP, then counter+(MAX_COUNT+1)-STEP and underflow=1; else counter-STEP.
  - Down, saturate: if counter < STEP, then 0 and underflow=1.
- Latency: counter updates on the clock edge ending the step cycle. overflow/underflow are registered and high for exactly the one cycle in which counter shows the post-step value; otherwise 0.
- at_max/at_min: decoded from the counter register, same-cycle with counter.
- Reset mid-operation or mid-prescale: all state cleared. The next step needs a full PRESCALE qualifying cycles.

Test Plan:
- Defaults; reset, enable=1, inc_en=1 for 16 cycles -> counter 1..15 then 0, single overflow pulse on 15->0, at_max high while 15. Then dec_en for 1 cycle -> 15 with underflow pulse.
- MAX_COUNT=9, STEP=3, wrap; inc from 0 -> 3,6,9,2(overflow),5,8,1(overflow). dec from 1 -> 8(underflow).
- MAX_COUNT=9, STEP=3, SATURATE=1; inc from 0 -> 3,6,9,9(overflow),9(overflow). dec -> 6,3,0,0(underflow). No pulse on 6->9.
- PRESCALE=4; inc held 12 cycles -> steps on 4th, 8th, 12th qualifying cycles (counter 3). Inc for 2 cycles, idle 5, inc 2 more -> exactly one step. inc_en=dec_en=1 for 4 cycles -> no change.
- MAX_COUNT=9; load_en with load_value=12 -> counter 9, at_max=1, no overflow. Load 5 with enable=0 -> 5. load_en with inc_en in the same cycle -> load value wins. Load mid-prescale -> prescale restarts.
- PRESCALE=4, counter=7 after 2 qualifying cycles; s_reset for 1 cycle -> counter 0, at_min=1, pulses 0. Next step occurs only after 4 further qualifying cycles.

Source files
------------

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, step, prescaler,
// wrap/saturate mode, synchronous load and boundary flags.
module updown_counter_mod #(
  parameter int          COUNT_WIDTH = 4,
  parameter int unsigned MAX_COUNT   = 15,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned STEP        = 1,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic                   clk,
  input  logic                   s_reset,
  input  logic                   enable,
  input  logic                   inc_en,
  input  logic                   dec_en,
  input  logic                   load_en,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic [COUNT_WIDTH-1:0] counter,
  output logic                   at_max,
  output logic                   at_min,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int W = COUNT_WIDTH;
  localparam logic [W:0] MAXV =
    (W+1)'(MAX_COUNT);
  localparam logic [W:0] STEPV =
    (W+1)'(STEP);
  localparam logic [W:0] MODV =
    (W+1)'(longint'(MAX_COUNT) + 1);
  localparam logic [W-1:0] MAXW =
    W'(MAX_COUNT);
  localparam logic [15:0] PS_LAST =
    16'(PRESCALE - 1);

  logic [15:0]  pcnt;
  logic [W:0]   cnt_ext;
  logic         qual;
  logic         fire;
  logic         up_hit;
  logic         dn_hit;
  logic [W-1:0] nxt;
  logic         nov;
  logic         nun;
  logic [W-1:0] ld_val;

  // All step arithmetic is one bit wider than the count so
  // MAX_COUNT+1 and counter+STEP never truncate.
  always_comb begin
    cnt_ext = {1'b0, counter};
    qual    = enable & (inc_en ^ dec_en);
    fire    = qual && (pcnt == PS_LAST);
    up_hit  = cnt_ext > (MAXV - STEPV);
    dn_hit  = cnt_ext < STEPV;
    nxt     = counter;
    nov     = 1'b0;
    nun     = 1'b0;
    if (inc_en) begin
      if (up_hit) begin
        nov = 1'b1;
        if (SATURATE)
          nxt = MAXW;
        else
          nxt = W'(cnt_ext + STEPV - MODV);
      end else begin
        nxt = W'(cnt_ext + STEPV);
      end
    end else begin
      if (dn_hit) begin
        nun = 1'b1;
        if (SATURATE)
          nxt = '0;
        else
          nxt = W'(cnt_ext + MODV - STEPV);
      end else begin
        nxt = W'(cnt_ext - STEPV);
      end
    end
    if ({1'b0, load_value} > MAXV)
      ld_val = MAXW;
    else
      ld_val = load_value;
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      counter   <= '0;
      pcnt      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (load_en) begin
      counter   <= ld_val;
      pcnt      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (fire) begin
      counter   <= nxt;
      pcnt      <= '0;
      overflow  <= nov;
      underflow <= nun;
    end else begin
      if (qual)
        pcnt <= pcnt + 16'd1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end
  end

  assign at_max = (counter == MAXW);
  assign at_min = (counter == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod across four
// parameter sets sharing one stimulus bus.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       s_reset = 1'b1;
  logic       enable = 1'b0;
  logic       inc_en = 1'b0;
  logic       dec_en = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_value = '0;

  logic [3:0] c0, c1, c2, c3;
  logic mx0, mn0, ov0, un0;
  logic mx1, mn1, ov1, un1;
  logic mx2, mn2, ov2, un2;
  logic mx3, mn3, ov3, un3;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  updown_counter_mod d0 (
    .clk(clk), .s_reset(s_reset), .enable(enable),
    .inc_en(inc_en), .dec_en(dec_en),
    .load_en(load_en), .load_value(load_value),
    .counter(c0), .at_max(mx0), .at_min(mn0),
    .overflow(ov0), .underflow(un0));

  updown_counter_mod #(
    .COUNT_WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0),
    .STEP(3), .PRESCALE(1)
  ) d1 (
    .clk(clk), .s_reset(s_reset), .enable(enable),
    .inc_en(inc_en), .dec_en(dec_en),
    .load_en(load_en), .load_value(load_value),
    .counter(c1), .at_max(mx1), .at_min(mn1),
    .overflow(ov1), .underflow(un1));

  updown_counter_mod #(
    .COUNT_WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1),
    .STEP(3), .PRESCALE(1)
  ) d2 (
    .clk(clk), .s_reset(s_reset), .enable(enable),
    .inc_en(inc_en), .dec_en(dec_en),
    .load_en(load_en), .load_value(load_value),
    .counter(c2), .at_max(mx2), .at_min(mn2),
    .overflow(ov2), .underflow(un2));

  updown_counter_mod #(
    .COUNT_WIDTH(4), .MAX_COUNT(15), .SATURATE(1'b0),
    .STEP(1), .PRESCALE(4)
  ) d3 (
    .clk(clk), .s_reset(s_reset), .enable(enable),
    .inc_en(inc_en), .dec_en(dec_en),
    .load_en(load_en), .load_value(load_value),
    .counter(c3), .at_max(mx3), .at_min(mn3),
    .overflow(ov3), .underflow(un3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b0; inc_en = 1'b0; dec_en = 1'b0;
    load_en = 1'b0; s_reset = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({c0, mx0, mn0, ov0, un0} !== 8'b0000_0100) begin
      mismatched++;
      $display("FAIL reset_d0: got %b want %b",
        {c0, mx0, mn0, ov0, un0}, 8'b0000_0100);
    end
    compared++;
    if ({c3, mx3, mn3, ov3, un3} !== 8'b0000_0100) begin
      mismatched++;
      $display("FAIL reset_d3: got %b want %b",
        {c3, mx3, mn3, ov3, un3}, 8'b0000_0100);
    end
  endtask

  task automatic test_default_wrap();
    logic [3:0] ec;
    do_reset();
    enable = 1'b1; inc_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      ec = 4'(i % 16);
      compared++;
      if ({c0, ov0, un0, mx0} !==
          {ec, (i == 16), 1'b0, (ec == 4'd15)}) begin
        mismatched++;
        $display("FAIL def_up[%0d]: got c=%0d ov=%b mx=%b want c=%0d",
          i, c0, ov0, mx0, ec);
      end
    end
    inc_en = 1'b0; dec_en = 1'b1;
    tick();
    compared++;
    if ({c0, ov0, un0} !== {4'd15, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL def_dn: got c=%0d ov=%b un=%b want c=15 un=1",
        c0, ov0, un0);
    end
    idle();
    tick();
    compared++;
    if ({c0, un0} !== {4'd15, 1'b0}) begin
      mismatched++;
      $display("FAIL def_hold: got c=%0d un=%b want c=15 un=0",
        c0, un0);
    end
  endtask

  task automatic test_step_wrap();
    int ec[7] = '{3, 6, 9, 2, 5, 8, 1};
    bit eo[7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    enable = 1'b1; inc_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      compared++;
      if ({c1, ov1, un1} !== {4'(ec[i]), eo[i], 1'b0}) begin
        mismatched++;
        $display("FAIL wrap_up[%0d]: got c=%0d ov=%b want c=%0d ov=%b",
          i, c1, ov1, ec[i], eo[i]);
      end
    end
    inc_en = 1'b0; dec_en = 1'b1;
    tick();
    compared++;
    if ({c1, ov1, un1} !== {4'd8, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL wrap_dn: got c=%0d un=%b want c=8 un=1",
        c1, un1);
    end
  endtask

  task automatic test_saturate();
    int uc[5] = '{3, 6, 9, 9, 9};
    bit uo[5] = '{0, 0, 0, 1, 1};
    int dc[4] = '{6, 3, 0, 0};
    bit du[4] = '{0, 0, 0, 1};
    do_reset();
    enable = 1'b1; inc_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if ({c2, ov2, un2, mx2} !==
          {4'(uc[i]), uo[i], 1'b0, (uc[i] == 9)}) begin
        mismatched++;
        $display("FAIL sat_up[%0d]: got c=%0d ov=%b mx=%b want c=%0d ov=%b",
          i, c2, ov2, mx2, uc[i], uo[i]);
      end
    end
    inc_en = 1'b0; dec_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if ({c2, ov2, un2, mn2} !==
          {4'(dc[i]), 1'b0, du[i], (dc[i] == 0)}) begin
        mismatched++;
        $display("FAIL sat_dn[%0d]: got c=%0d un=%b mn=%b want c=%0d un=%b",
          i, c2, un2, mn2, dc[i], du[i]);
      end
    end
  endtask

  task automatic test_prescale();
    do_reset();
    enable = 1'b1; inc_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      compared++;
      if (c3 !== 4'(i / 4)) begin
        mismatched++;
        $display("FAIL ps_run[%0d]: got %0d want %0d", i, c3, i / 4);
      end
    end
    tick();
    tick();
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    tick();
    compared++;
    if (c3 !== 4'd3) begin
      mismatched++;
      $display("FAIL ps_gap_early: got %0d want 3", c3);
    end
    tick();
    compared++;
    if (c3 !== 4'd4) begin
      mismatched++;
      $display("FAIL ps_gap_step: got %0d want 4", c3);
    end
    dec_en = 1'b1;
    repeat (4) tick();
    compared++;
    if ({c3, ov3, un3} !== {4'd4, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL ps_both: got %0d want 4", c3);
    end
  endtask

  task automatic test_load();
    do_reset();
    load_en = 1'b1; load_value = 4'd12;
    tick();
    compared++;
    if ({c1, mx1, ov1} !== {4'd9, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL load_clamp: got c=%0d mx=%b ov=%b want c=9 mx=1 ov=0",
        c1, mx1, ov1);
    end
    load_value = 4'd5;
    tick();
    compared++;
    if (c1 !== 4'd5) begin
      mismatched++;
      $display("FAIL load_noen: got %0d want 5", c1);
    end
    enable = 1'b1; inc_en = 1'b1; load_value = 4'd2;
    tick();
    compared++;
    if ({c1, ov1} !== {4'd2, 1'b0}) begin
      mismatched++;
      $display("FAIL load_vs_inc: got %0d want 2", c1);
    end
    do_reset();
    enable = 1'b1; inc_en = 1'b1;
    tick();
    tick();
    load_en = 1'b1; load_value = 4'd7;
    tick();
    load_en = 1'b0;
    repeat (3) tick();
    compared++;
    if (c3 !== 4'd7) begin
      mismatched++;
      $display("FAIL load_ps_hold: got %0d want 7", c3);
    end
    tick();
    compared++;
    if (c3 !== 4'd8) begin
      mismatched++;
      $display("FAIL load_ps_step: got %0d want 8", c3);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_en = 1'b1; load_value = 4'd7;
    tick();
    load_en = 1'b0; enable = 1'b1; inc_en = 1'b1;
    tick();
    tick();
    compared++;
    if (c3 !== 4'd7) begin
      mismatched++;
      $display("FAIL rmid_pre: got %0d want 7", c3);
    end
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    compared++;
    if ({c3, mn3, ov3, un3} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL rmid_rst: got %b want %b",
        {c3, mn3, ov3, un3}, 7'b0000_100);
    end
    repeat (3) tick();
    compared++;
    if (c3 !== 4'd0) begin
      mismatched++;
      $display("FAIL rmid_hold: got %0d want 0", c3);
    end
    tick();
    compared++;
    if (c3 !== 4'd1) begin
      mismatched++;
      $display("FAIL rmid_step: got %0d want 1", c3);
    end
  endtask

  initial begin
    test_reset();
    test_default_wrap();
    test_step_wrap();
    test_saturate();
    test_prescale();
    test_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      compared, mismatched);
    $finish;
  end

endmodule
